bram_ctrl: RTL
==============

# bram_ctrl

Sequencer for the single-chunk local `bram` buffer. It fills the buffer from the global-memory read channel and arbitrates byte-level host reads and writes against chunk traffic. It tracks the dirty state and writes the chunk back to global memory on flush, or automatically before a reload. It sits between the host byte port, the global-memory chunk channels and one `bram` instance.

## Interface
- `NUM_BITS`, 512: chunk width; must be a multiple of 8.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `load_req`, `flush_req`  in  1  level requests, sampled in IDLE/SERVE.
- `mem_rd_valid` in 1, `mem_rd_ready` out 1, `mem_rd_data` in NUM_BITS: chunk fill channel.
- `mem_wr_valid` out 1, `mem_wr_ready` in 1, `mem_wr_data` out NUM_BITS: writeback channel.
- `host_req_valid` in 1, `host_req_ready` out 1, `host_req_we` in 1, `host_req_offset` in 8, `host_req_wdata` in 8: host byte request.
- `host_rsp_valid` out 1, `host_rsp_data` out 8, `host_rsp_err` out 1: host response.
- `bram_chunk_wr` out 1, `bram_chunk_in` out NUM_BITS: drive the bram chunk-load port.
- `bram_byte_wr` out 1, `bram_offset` out 8, `bram_byte_in` out 8: drive the bram host port.
- `bram_byte_out` in 8, `bram_chunk_out` in NUM_BITS: bram read data (combinational).
- `chunk_valid`, `dirty`, `busy`  out 1  status.
- `load_done`, `flush_done`  out 1  one-cycle completion pulses.

## Operation
- States:
  - IDLE: no chunk.
  - LOAD: waiting on the read channel.
  - SERVE: chunk resident; host served.
  - FLUSH: writeback in progress.
- Reset (`rst`=0 at edge): state IDLE, `pending_load`=0. Every output is 0. `chunk_valid`, `dirty` and `busy` reset to 0. A reset mid-LOAD or mid-FLUSH abandons the transfer; `mem_*` valid/ready are 0 from the next cycle.
- IDLE: `load_req` -> LOAD. `flush_req` is ignored.
- LOAD:
  - `mem_rd_ready`=1.
  - On `mem_rd_valid`: `bram_chunk_wr`=1 and `bram_chunk_in`=`mem_rd_data` in the same cycle (pass-through).
  - Next state SERVE with `chunk_valid`=1, `dirty`=0, `load_done` pulse, `pending_load`=0.
- SERVE, evaluated in priority order:
  1. `load_req` with `dirty`=1 -> FLUSH, `pending_load`=1.
  2. `load_req` with `dirty`=0 -> LOAD.
  3. `flush_req` with `dirty`=1 -> FLUSH.
  4. `flush_req` with `dirty`=0 -> `flush_done` pulse next cycle; stay in SERVE.
  5. Otherwise serve the host.
- `host_req_ready` = (state==SERVE) & !`load_req` & !`flush_req`. Host requests are never accepted in other states.
- Accepted host request, offset < NUM_BITS/8:
  - Write: `bram_byte_wr`=1, `bram_offset`=offset, `bram_byte_in`=wdata in the same cycle; `dirty`<=1.
  - Read: `bram_offset`=offset; `bram_byte_out` is captured into `host_rsp_data`.
- Accepted host request, offset >= NUM_BITS/8: no bram access; `host_rsp_err`=1, `host_rsp_data`=0.
- Every accepted request gets exactly one response. For writes, `host_rsp_data`=0.
- FLUSH:
  - `mem_wr_valid`=1 and `mem_wr_data`=`bram_chunk_out`, held stable until `mem_wr_ready`.
  - On handshake: `dirty`<=0, `flush_done` pulse, next state LOAD if `pending_load`, else SERVE.
- `busy` = state is LOAD or FLUSH.
- When idle, `bram_offset` holds 0 and `bram_byte_in` holds 0.

## Timing
- Host access: accept at cycle N; `host_rsp_valid` is a 1-cycle pulse at N+1 with data and err. Throughput is one request per cycle.
- Back-to-back write then read of the same offset (N, N+1) returns the new byte at N+2.
- Load: read handshake at N. `chunk_valid`=1, `load_done`=1 and state SERVE at N+1. The first host accept is possible at N+1.
- Flush: `mem_wr_valid` rises the cycle after the entry decision. The handshake cycle is the last cycle valid is asserted; `flush_done` pulses the next cycle.
- Dirty reload: the flush handshake at N gives `mem_rd_ready`=1 at N+1. Minimum 2 cycles from request to LOAD when `mem_wr_ready` is already high.
- `host_req_ready` drops combinationally in the same cycle `load_req`/`flush_req` rise. No host write can land after the flush snapshot.

## Structure
- Shared package `bram_ctrl_pkg`:
  - state enum (IDLE, LOAD, SERVE, FLUSH)
  - `BYTES_PER_CHUNK` = NUM_BITS/8
  - offset width constant (8)
- Single module with no sub-module. The response register and FSM are inline.

## Test plan
- Reset, load, read: hold `rst`=0 for 2 cycles; all outputs are 0. Assert `load_req` and return `mem_rd_data` with byte 5 = 0xA5. Read offset 5 -> `host_rsp_data`=0xA5, err=0, one cycle after accept. `dirty`=0.
- Write/read-back: write 0x3C to offset 10, then read offset 10 on the next cycle -> 0x3C. `dirty`=1.
- Out-of-range: read offset 64 with NUM_BITS=512 -> `host_rsp_err`=1, data=0, `bram_byte_wr` never asserted.
- Flush with backpressure: make the chunk dirty, `flush_req`, hold `mem_wr_ready`=0 for 3 cycles. `mem_wr_data` is stable and equals the chunk with 0x3C at byte 10. `host_req_ready`=0 throughout. After the handshake, `dirty`=0 and `flush_done` pulses once.
- Dirty reload: `load_req` while dirty -> the flush completes first, then `mem_rd_ready`=1. The new chunk gives `chunk_valid`=1 and `dirty`=0.
- Reset mid-LOAD: `rst`=0 while `mem_rd_ready`=1 -> next cycle in IDLE with `mem_rd_ready`=0 and `chunk_valid`=0. A later `mem_rd_valid` is ignored.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared types and constants for the single-chunk bram sequencer.
package bram_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StServe,
    StFlush
  } state_e;

  localparam int unsigned OFFSET_W = 8;
  localparam int unsigned DEFAULT_NUM_BITS = 512;

  function automatic int unsigned bytes_per_chunk(input int unsigned num_bits);
    return num_bits / 8;
  endfunction

  localparam int unsigned BYTES_PER_CHUNK = bytes_per_chunk(DEFAULT_NUM_BITS);

endpackage

// File: rtl/bram_ctrl.sv
// Fills the local bram chunk from global memory, serves host byte accesses against it and
// writes it back on flush or before a reload of a dirty chunk.
module bram_ctrl
  import bram_ctrl_pkg::*;
#(
  parameter int unsigned NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req,
  input  logic                flush_req,
  input  logic                mem_rd_valid,
  output logic                mem_rd_ready,
  input  logic [NUM_BITS-1:0] mem_rd_data,
  output logic                mem_wr_valid,
  input  logic                mem_wr_ready,
  output logic [NUM_BITS-1:0] mem_wr_data,
  input  logic                host_req_valid,
  output logic                host_req_ready,
  input  logic                host_req_we,
  input  logic [OFFSET_W-1:0] host_req_offset,
  input  logic [7:0]          host_req_wdata,
  output logic                host_rsp_valid,
  output logic [7:0]          host_rsp_data,
  output logic                host_rsp_err,
  output logic                bram_chunk_wr,
  output logic [NUM_BITS-1:0] bram_chunk_in,
  output logic                bram_byte_wr,
  output logic [OFFSET_W-1:0] bram_offset,
  output logic [7:0]          bram_byte_in,
  input  logic [7:0]          bram_byte_out,
  input  logic [NUM_BITS-1:0] bram_chunk_out,
  output logic                chunk_valid,
  output logic                dirty,
  output logic                busy,
  output logic                load_done,
  output logic                flush_done
);

  localparam int unsigned Bytes = bytes_per_chunk(NUM_BITS);

  state_e state_q;
  logic   pending_load_q;
  logic   host_acc;
  logic   in_range;
  logic   rd_hs;

  // Any pending chunk request blocks the host so no write lands after the flush snapshot.
  assign host_req_ready = (state_q == StServe) && !load_req && !flush_req;
  assign host_acc       = host_req_ready && host_req_valid;
  assign in_range       = 32'(host_req_offset) < Bytes;

  assign mem_rd_ready  = (state_q == StLoad);
  assign rd_hs         = mem_rd_ready && mem_rd_valid;
  assign bram_chunk_wr = rd_hs;
  assign bram_chunk_in = rd_hs ? mem_rd_data : '0;

  assign mem_wr_valid = (state_q == StFlush);
  assign mem_wr_data  = mem_wr_valid ? bram_chunk_out : '0;

  assign bram_byte_wr = host_acc && in_range && host_req_we;
  assign bram_offset  = (host_acc && in_range) ? host_req_offset : '0;
  assign bram_byte_in = bram_byte_wr ? host_req_wdata : '0;

  assign busy = (state_q == StLoad) || (state_q == StFlush);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= StIdle;
      pending_load_q <= 1'b0;
      chunk_valid    <= 1'b0;
      dirty          <= 1'b0;
      load_done      <= 1'b0;
      flush_done     <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
      host_rsp_err   <= 1'b0;
    end else begin
      load_done      <= 1'b0;
      flush_done     <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
      host_rsp_err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_req) state_q <= StLoad;
        end
        StLoad: begin
          if (mem_rd_valid) begin
            state_q        <= StServe;
            chunk_valid    <= 1'b1;
            dirty          <= 1'b0;
            load_done      <= 1'b1;
            pending_load_q <= 1'b0;
          end
        end
        StServe: begin
          if (load_req && dirty) begin
            state_q        <= StFlush;
            pending_load_q <= 1'b1;
          end else if (load_req) begin
            state_q <= StLoad;
          end else if (flush_req && dirty) begin
            state_q <= StFlush;
          end else if (flush_req) begin
            flush_done <= 1'b1;
          end else if (host_acc) begin
            host_rsp_valid <= 1'b1;
            host_rsp_err   <= !in_range;
            if (in_range && !host_req_we) host_rsp_data <= bram_byte_out;
            if (in_range && host_req_we) dirty <= 1'b1;
          end
        end
        StFlush: begin
          if (mem_wr_ready) begin
            dirty      <= 1'b0;
            flush_done <= 1'b1;
            state_q    <= pending_load_q ? StLoad : StServe;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
